// File: rtl/twitchcore_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : twitchcore_mem_arbiter
//  Description : Shares one single-port synchronous RAM between the fetch
//                port (i_*) and the load/store port (d_*). At most one grant
//                per cycle; read data returns one cycle after the grant and
//                is tagged to the requester that issued it.
//                Default: data has priority, and a starvation counter forces
//                fetch to win after STARVE_MAX denied cycles.
//                Optional macro MEMARB_RR_EN: round-robin arbitration instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module twitchcore_mem_arbiter #(
  parameter int MEM_AW     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [MEM_AW-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_RD_I = 2'd1,
    TAG_RD_D = 2'd2
  } rd_tag_t;

  rd_tag_t r_rd_tag;
  rd_tag_t w_rd_tag_nxt;

  logic w_pick_d;
  logic w_gnt_i;
  logic w_gnt_d;

`ifdef MEMARB_RR_EN
  // 1 = data port won the most recent grant; reset to data so fetch wins first
  logic r_last_gnt_d;

  assign w_pick_d = d_req & (~i_req | ~r_last_gnt_d);

  // remember which port won last so a conflict goes to the other one
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_last_gnt_d <= 1'b1;
    end else if (w_gnt_i) begin
      r_last_gnt_d <= 1'b0;
    end else if (w_gnt_d) begin
      r_last_gnt_d <= 1'b1;
    end
  end
`else
  localparam int c_CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);

  logic [c_CNT_W-1:0] r_starve_cnt;
  logic               w_starved;

  assign w_starved = (r_starve_cnt == c_STARVE_MAX);
  assign w_pick_d  = d_req & (~i_req | ~w_starved);

  // count consecutive cycles fetch is held off, saturating at the bound
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_starve_cnt <= '0;
    end else if (~i_req | w_gnt_i) begin
      r_starve_cnt <= '0;
    end else if (~w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`endif

  // grants are suppressed entirely while reset is asserted
  assign w_gnt_d = ~resetn & w_pick_d;
  assign w_gnt_i = ~resetn & i_req & ~w_pick_d;
  assign i_gnt   = w_gnt_i;
  assign d_gnt   = w_gnt_d;
  assign m_en    = w_gnt_i | w_gnt_d;

  // steer the winning request onto the RAM port; idle port drives zeros
  always_comb begin
    m_we    = 1'b0;
    m_be    = 4'h0;
    m_addr  = '0;
    m_wdata = 32'h0;
    if (w_gnt_d) begin
      m_we    = d_we;
      m_be    = d_be;
      m_addr  = d_addr[MEM_AW+1:2];
      m_wdata = d_wdata;
    end else if (w_gnt_i) begin
      m_be    = 4'hF;
      m_addr  = i_addr[MEM_AW+1:2];
    end
  end

  // tag the next-cycle RAM output with the port whose read was granted
  always_comb begin
    w_rd_tag_nxt = TAG_NONE;
    if (w_gnt_i) begin
      w_rd_tag_nxt = TAG_RD_I;
    end else if (w_gnt_d && !d_we) begin
      w_rd_tag_nxt = TAG_RD_D;
    end
  end

  // response tag register
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_rd_tag <= TAG_NONE;
    end else begin
      r_rd_tag <= w_rd_tag_nxt;
    end
  end

  assign i_rvalid = ~resetn & (r_rd_tag == TAG_RD_I);
  assign d_rvalid = ~resetn & (r_rd_tag == TAG_RD_D);
  assign busy     = ~resetn & (r_rd_tag != TAG_NONE);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

  // byte-offset and above-depth address bits are deliberately ignored
  logic w_unused_addr_bits;
  assign w_unused_addr_bits = ^{i_addr[1:0], i_addr[31:MEM_AW+2],
                                d_addr[1:0], d_addr[31:MEM_AW+2]};

endmodule
`default_nettype wire

// File: tb/tb_twitchcore_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_twitchcore_mem_arbiter
//  Description : Bench for twitchcore_mem_arbiter with a behavioural RAM and
//                a transaction-level reference model (MEMARB_RR_EN aware).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_twitchcore_mem_arbiter;
  localparam int MEM_AW     = 14;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt, i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req, d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_addr, d_wdata;
  logic              d_gnt, d_rvalid;
  logic [31:0]       d_rdata;
  logic              m_en, m_we;
  logic [3:0]        m_be;
  logic [MEM_AW-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;
  logic              busy;

  always #5 clk = ~clk;

  twitchcore_mem_arbiter #(.MEM_AW(MEM_AW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  // single-port synchronous RAM with byte-enabled writes
  logic [31:0] ram [0:(1<<MEM_AW)-1];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        ram_q <= ram[m_addr];
      end
    end
  end
  assign m_rdata = ram_q;

  // reference model state
  int          errors = 0;
  int          checks = 0;
  int          denied = 0;        // consecutive cycles fetch asked and lost
  bit          last_was_d = 1'b1; // round-robin history
  bit          exp_iv = 1'b0, exp_dv = 1'b0;
  logic [31:0] exp_rd = 32'h0;
  logic [31:0] shadow [int];      // memory contents as seen by completed writes
  bit          last_gi, last_gd;  // model grant decision of the latest cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check one cycle against the model, advance the model, move to next cycle.
  // Called just after a negedge with the cycle's inputs already applied.
  task automatic tick();
    bit gi, gd;
    int wa;
    logic [31:0] wd;
    #1;
    gi = 1'b0;
    gd = 1'b0;
    if (!resetn) begin
      if (i_req && d_req) begin
`ifdef MEMARB_RR_EN
        gi = last_was_d;
`else
        gi = (denied >= STARVE_MAX);
`endif
        gd = !gi;
      end else begin
        gi = i_req;
        gd = d_req;
      end
    end
    wa = gd ? int'(d_addr[MEM_AW+1:2]) : gi ? int'(i_addr[MEM_AW+1:2]) : 0;
    chk("i_gnt",   i_gnt,   gi);
    chk("d_gnt",   d_gnt,   gd);
    chk("m_en",    m_en,    gi | gd);
    chk("m_addr",  m_addr,  wa);
    chk("m_we",    m_we,    gd & d_we);
    chk("m_be",    m_be,    gd ? d_be : gi ? 4'hF : 4'h0);
    chk("m_wdata", m_wdata, gd ? d_wdata : 32'h0);
    chk("i_rvalid", i_rvalid, !resetn && exp_iv);
    chk("d_rvalid", d_rvalid, !resetn && exp_dv);
    chk("busy",     busy,     !resetn && (exp_iv || exp_dv));
    if (!resetn && exp_iv) chk("i_rdata", i_rdata, exp_rd);
    if (!resetn && exp_dv) chk("d_rdata", d_rdata, exp_rd);
    last_gi = gi;
    last_gd = gd;
    if (resetn) begin
      denied = 0;
      last_was_d = 1'b1;
      exp_iv = 1'b0;
      exp_dv = 1'b0;
    end else begin
      if (i_req && !gi) denied = (denied < STARVE_MAX) ? denied + 1 : STARVE_MAX;
      else              denied = 0;
      if (gi) last_was_d = 1'b0;
      else if (gd) last_was_d = 1'b1;
      exp_iv = gi;
      exp_dv = gd && !d_we;
      if (exp_iv || exp_dv) exp_rd = shadow[wa];
      if (gd && d_we) begin
        wd = shadow.exists(wa) ? shadow[wa] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (d_be[b]) wd[8*b +: 8] = d_wdata[8*b +: 8];
        shadow[wa] = wd;
      end
    end
    @(negedge clk);
  endtask

  // keep ticking until both requesters have been served
  task automatic drain();
    for (int k = 0; k < 12 && (i_req || d_req); k++) begin
      tick();
      if (last_gi) i_req = 1'b0;
      if (last_gd) d_req = 1'b0;
    end
    chk("drain_done", {i_req, d_req}, 2'b00);
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    return a & ~32'h0000_FF80;  // word index 0..31, random high and byte bits
  endfunction

  logic [1:0] pat [10];
  logic [31:0] tmp;

  initial begin
    resetn = 1'b1; i_req = 1'b1; i_addr = 32'h44; d_req = 1'b1; d_we = 1'b1;
    d_be = 4'hF; d_addr = 32'h8; d_wdata = 32'h5555_5555;
    @(negedge clk);
    // reset holds every output low even with requests pending
    tick(); tick();
    resetn = 1'b0; i_req = 1'b0;
    // preload words 0..31 through the data port
    for (int w = 0; w < 32; w++) begin
      d_req = 1'b1; d_we = 1'b1; d_be = 4'hF; d_addr = 32'(w) << 2;
      d_wdata = (w == 4) ? 32'hDEAD_BEEF : (w == 8) ? 32'hAAAA_AAAA :
                (w == 2) ? 32'h2222_2222 : (32'hC0DE_0000 | 32'(w));
      tick();
    end
    d_req = 1'b0;
    resetn = 1'b1;
    tick();

    // first fetch after reset release
    resetn = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0010;
    #1; chk("fetch_gnt", i_gnt, 1'b1); chk("fetch_maddr", m_addr, 14'd4);
    tick();
    i_req = 1'b0;
    #1; chk("fetch_rvalid", i_rvalid, 1'b1); chk("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("fetch_no_drvalid", d_rvalid, 1'b0);
    tick();

    // partial store then load-back
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h20; d_wdata = 32'h1234_5678;
    #1; chk("store_gnt", d_gnt, 1'b1);
    tick();
    d_we = 1'b0; d_be = 4'hF;
    #1; chk("store_no_rvalid", d_rvalid, 1'b0);
    tick();
    d_req = 1'b0;
    #1; chk("load_rvalid", d_rvalid, 1'b1); chk("load_rdata", d_rdata, 32'hAAAA_5678);
    tick();

    // sustained conflict: fetch and load both held for 10 cycles
`ifdef MEMARB_RR_EN
    for (int k = 0; k < 10; k++) pat[k] = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
    for (int k = 0; k < 10; k++) pat[k] = (k % 5 == 4) ? 2'b10 : 2'b01;
`endif
    i_req = 1'b1; i_addr = 32'h0000_0014; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0018;
    for (int k = 0; k < 10; k++) begin
      #1; chk("conflict_pattern", {i_gnt, d_gnt}, pat[k]);
      tick();
    end
    drain();

    // fetch granted, then reset on the following cycle kills the response
    i_req = 1'b1; i_addr = 32'h0000_0010;
    tick();
    i_req = 1'b0; resetn = 1'b1;
    #1;
    chk("rst_outputs", {i_gnt, d_gnt, m_en, m_we, m_be, i_rvalid, d_rvalid, busy}, 12'h0);
    chk("rst_maddr", m_addr, 14'h0); chk("rst_mwdata", m_wdata, 32'h0);
    tick(); tick();
    resetn = 1'b0;
    #1; chk("post_rst_no_rvalid", i_rvalid, 1'b0); chk("post_rst_busy", busy, 1'b0);
    tick();

    // high address bits wrap
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hFFFF_0008;
    #1; chk("wrap_maddr", m_addr, 14'd2);
    tick();
    d_req = 1'b0;
    #1; chk("wrap_rvalid", d_rvalid, 1'b1); chk("wrap_rdata", d_rdata, 32'h2222_2222);
    tick();

    // randomized traffic obeying the hold-until-grant protocol
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 59) == 0);
      if (!i_req && $urandom_range(0, 2) != 0) begin
        i_req = 1'b1; i_addr = rand_addr();
      end
      if (!d_req && $urandom_range(0, 2) != 0) begin
        d_req = 1'b1; d_we = $urandom_range(0, 2) == 0; d_be = 4'($urandom);
        d_addr = rand_addr(); tmp = $urandom; d_wdata = tmp;
      end
      tick();
      if (last_gi) i_req = 1'b0;
      if (last_gd) d_req = 1'b0;
    end
    resetn = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // absolute time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
